// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and a per-register
// pending-claim counter used by decode for hazard detection.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              claim_stall
);

  localparam logic [ADDR_W:0]   REG_COUNT = (ADDR_W+1)'(NUM_REGS);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  logic [DATA_W-1:0] data_mem [NUM_REGS];
  logic [PEND_W-1:0] pend_reg [NUM_REGS];

  logic wr_ok;
  logic claim_ok;
  logic claim_take;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < REG_COUNT;
  endfunction

  // Writable/claimable: in range and not the hardwired zero register.
  function automatic logic usable(input logic [ADDR_W-1:0] addr);
    return in_range(addr) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  assign wr_ok       = wr_en && usable(wr_addr);
  assign claim_ok    = claim_en && usable(claim_addr);
  // Stall looks only at the stored counter; a same-cycle release does not unblock it.
  assign claim_stall = !rst && claim_ok && (pend_reg[claim_addr] == PEND_MAX);
  assign claim_take  = claim_ok && !claim_stall;

  genvar gi;
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
    logic hit_wr;
    logic hit_claim;
    logic hit_rel;

    assign hit_wr    = wr_ok && (wr_addr == IDX);
    assign hit_claim = claim_take && (claim_addr == IDX);
    assign hit_rel   = hit_wr && (pend_reg[gi] != '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        data_mem[gi] <= '0;
        pend_reg[gi] <= '0;
      end else begin
        if (hit_wr) begin
          data_mem[gi] <= wr_data;
        end
        if (hit_claim && !hit_rel) begin
          pend_reg[gi] <= pend_reg[gi] + PEND_ONE;
        end else if (hit_rel && !hit_claim) begin
          pend_reg[gi] <= pend_reg[gi] - PEND_ONE;
        end
      end
    end
  end

  for (gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = (gi == 0) ? rd_addr1 : rd_addr2;

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (!rst && in_range(addr)) begin
        data = data_mem[addr];
        busy = (pend_reg[addr] != '0);
        if ((BYPASS != 0) && wr_ok && (wr_addr == addr)) begin
          data = wr_data;
          // The last outstanding claim is released now, unless a new claim lands alongside it.
          if ((pend_reg[addr] == PEND_ONE) && !(claim_take && (claim_addr == addr))) begin
            busy = 1'b0;
          end
        end
      end
    end
  end

  assign rd_data1 = g_rd[0].data;
  assign rd_busy1 = g_rd[0].busy;
  assign rd_data2 = g_rd[1].data;
  assign rd_busy2 = g_rd[1].busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic checked against
// an array/counter model of the register file and scoreboard.
module tb_regfile_scoreboard;

  localparam int DW   = 16;
  localparam int NR   = 16;
  localparam int AW   = 4;
  localparam int PMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, claim_addr;
  logic [DW-1:0] rd_data1, rd_data2, wr_data;
  logic          rd_busy1, rd_busy2, wr_en, claim_en, claim_stall;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [DW-1:0] m_data [NR];
  int            m_pend [NR];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr1   (rd_addr1),
    .rd_data1   (rd_data1),
    .rd_busy1   (rd_busy1),
    .rd_addr2   (rd_addr2),
    .rd_data2   (rd_data2),
    .rd_busy2   (rd_busy2),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .claim_stall(claim_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn, got, exp);
    end
  endtask

  function automatic bit writable(input int a);
    return (a != 0) && (a < NR);
  endfunction

  function automatic bit claim_accepted();
    return !rst && claim_en && writable(int'(claim_addr)) && (m_pend[claim_addr] < PMAX);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int a);
    if (rst || a == 0) return '0;
    if (wr_en && writable(int'(wr_addr)) && int'(wr_addr) == a) return wr_data;
    return m_data[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (rst) return 1'b0;
    if (wr_en && writable(int'(wr_addr)) && int'(wr_addr) == a && m_pend[a] == 1 &&
        !(claim_accepted() && int'(claim_addr) == a)) return 1'b0;
    return m_pend[a] != 0;
  endfunction

  // Drive one cycle's inputs, let them settle, and compare every output with the model.
  task automatic apply(input bit r, input bit we, input int wa, input int wd,
                       input bit ce, input int ca, input int a1, input int a2);
    rst = r; wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
    claim_en = ce; claim_addr = AW'(ca); rd_addr1 = AW'(a1); rd_addr2 = AW'(a2);
    #1;
    txn++;
    $display("txn %0d rst=%0d wr=%0d@%0d=%h claim=%0d@%0d rd1@%0d=%h/%0d rd2@%0d=%h/%0d stall=%0d",
             txn, r, we, wa, wr_data, ce, ca, a1, rd_data1, rd_busy1, a2, rd_data2, rd_busy2,
             claim_stall);
    check_eq("rd_data1", 32'(rd_data1), 32'(exp_data(a1)));
    check_eq("rd_data2", 32'(rd_data2), 32'(exp_data(a2)));
    check_eq("rd_busy1", 32'(rd_busy1), 32'(exp_busy(a1)));
    check_eq("rd_busy2", 32'(rd_busy2), 32'(exp_busy(a2)));
    check_eq("claim_stall", 32'(claim_stall),
             32'(!rst && claim_en && writable(ca) && m_pend[ca] == PMAX));
  endtask

  // Clock edge, then advance the model with the inputs that were sampled.
  task automatic tick();
    bit acc, rel;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_data[i] = '0;
        m_pend[i] = 0;
      end
    end else begin
      acc = claim_accepted();
      rel = wr_en && writable(int'(wr_addr)) && m_pend[wr_addr] > 0;
      if (wr_en && writable(int'(wr_addr))) m_data[wr_addr] = wr_data;
      if (acc) m_pend[claim_addr] = m_pend[claim_addr] + 1;
      if (rel) m_pend[wr_addr] = m_pend[wr_addr] - 1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_data[i] = '0;
      m_pend[i] = 0;
    end

    // Reset, then sweep every address on both ports.
    apply(1, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < NR; i++) begin
      apply(0, 0, 0, 0, 0, 0, i, NR - 1 - i);
      check_eq("sweep_data", 32'(rd_data1), 32'h0);
      check_eq("sweep_busy", 32'(rd_busy2), 32'h0);
      tick();
    end

    // Write bypass, then the stored value.
    apply(0, 1, 5, 'hBEEF, 0, 0, 5, 0);
    check_eq("bypass_beef", 32'(rd_data1), 32'hBEEF);
    tick();
    apply(0, 0, 0, 0, 0, 0, 5, 5);
    check_eq("stored_beef", 32'(rd_data2), 32'hBEEF);
    tick();

    // Register 0 ignores writes and claims.
    apply(0, 1, 0, 'h1234, 1, 0, 0, 0);
    check_eq("zero_stall", 32'(claim_stall), 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("zero_data", 32'(rd_data1), 32'h0);
      check_eq("zero_busy", 32'(rd_busy1), 32'h0);
      tick();
    end

    // Saturate reg 3, then drain it.
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 1, 3, 3, 3);
      if (i > 0) check_eq("sat_busy", 32'(rd_busy1), 32'h1);
      tick();
    end
    apply(0, 0, 0, 0, 1, 3, 3, 3);
    check_eq("sat_stall", 32'(claim_stall), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 3, 'h0300 + i, 0, 0, 3, 3);
      check_eq("drain_busy", 32'(rd_busy1), (i == 2) ? 32'h0 : 32'h1);
      tick();
    end

    // Claim and release of reg 7 in the same cycle keeps it pending.
    apply(0, 0, 0, 0, 1, 7, 7, 7); tick();
    apply(0, 1, 7, 'h0777, 1, 7, 7, 7);
    check_eq("clrel_busy_now", 32'(rd_busy1), 32'h1);
    tick();
    apply(0, 0, 0, 0, 0, 0, 7, 7);
    check_eq("clrel_busy_next", 32'(rd_busy1), 32'h1);
    tick();

    // Mid-operation reset discards claims and a concurrent write.
    apply(0, 0, 0, 0, 1, 2, 2, 4); tick();
    apply(0, 0, 0, 0, 1, 4, 2, 4); tick();
    apply(1, 1, 2, 'hAAAA, 0, 0, 2, 4); tick();
    apply(0, 0, 0, 0, 0, 0, 2, 4);
    check_eq("rst_data2", 32'(rd_data1), 32'h0);
    check_eq("rst_busy2", 32'(rd_busy1), 32'h0);
    check_eq("rst_busy4", 32'(rd_busy2), 32'h0);
    tick();

    // Random traffic concentrated on a few registers so counters saturate.
    for (int n = 0; n < 1500; n++) begin
      int wa, a2;
      wa = $urandom_range(0, 7);
      a2 = ($urandom_range(0, 1) == 1) ? wa : $urandom_range(0, NR - 1);
      apply($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, wa, $urandom_range(0, 65535),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, NR - 1), a2);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with two read ports, one write port, same-cycle write-to-read bypass, and a per-register pending counter (scoreboard). It is the next generation of the storage array used by the pipeline's decode stage. Issue logic claims a destination register, and writeback stores the result and releases the claim. Decode reads operands together with a busy flag for hazard detection.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 16, number of registers
- ADDR_W, $clog2(NUM_REGS), register address width
- PEND_W, 2, width of each pending counter; max outstanding claims per register = 2^PEND_W-1
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and claims, and is never busy
- BYPASS, 1, when 1 enables the same-cycle write-to-read bypass and release-to-busy bypass

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr1  in  ADDR_W  read port 1 address
- rd_data1  out  DATA_W  read port 1 data, combinational
- rd_busy1  out  1  register at rd_addr1 has an outstanding claim
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data2  out  DATA_W  read port 2 data, combinational
- rd_busy2  out  1  register at rd_addr2 has an outstanding claim
- wr_en  in  1  writeback valid
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback value
- claim_en  in  1  issue request to mark claim_addr pending
- claim_addr  in  ADDR_W  register to claim
- claim_stall  out  1  combinational; claim refused this cycle

## Operation
- State:
  - data array NUM_REGS x DATA_W.
  - pend counter NUM_REGS x PEND_W.
- Reset, on any edge with rst=1:
  - All data words and all pend counters go to 0.
  - wr_en and claim_en are ignored that cycle.
  - This holds for reset asserted mid-operation.
- Writeback, when wr_en=1 and the address is writable (not reg 0 when ZERO_REG=1):
  - data[wr_addr] takes wr_data at the edge.
  - pend[wr_addr] decrements if it is nonzero. A write to a register with pend=0 is a plain write with no underflow.
- Claim:
  - Accepted when claim_en=1, the address is claimable, and claim_stall=0.
  - An accepted claim increments pend[claim_addr].
- claim_stall is 1 only when claim_en=1, the address is claimable, and pend[claim_addr] equals its maximum value.
- Release in the same cycle as a stalled claim:
  - A writeback release to the same address in the same cycle does not clear claim_stall. Stall is computed from the current counter only.
  - The release still decrements the counter.
- Simultaneous accepted claim and writeback release to the same address: pend is unchanged.
- Read data:
  - rd_dataN = data[rd_addrN].
  - If BYPASS=1, wr_en=1, wr_addr==rd_addrN and the address is writable, rd_dataN = wr_data instead.
  - When ZERO_REG=1 and rd_addrN==0, rd_dataN = 0 regardless of wr_en.
- Read busy:
  - rd_busyN = (pend[rd_addrN] != 0).
  - If BYPASS=1, a same-cycle release forces rd_busyN=0 when pend==1 and there is no concurrent claim to the same address.
  - A same-cycle claim is never forwarded to rd_busyN. It becomes visible on the next cycle.
- Both read ports are independent and may use the same address.

## Timing
- Read latency is 0 cycles (combinational from address).
- Write-to-read latency:
  - 0 cycles with BYPASS=1.
  - 1 cycle with BYPASS=0.
- Claim-to-busy latency is 1 cycle.
- Release-to-not-busy latency:
  - 0 cycles with BYPASS=1.
  - 1 cycle with BYPASS=0.
- Outputs during reset and the cycle after:
  - rd_data1/2=0 and rd_busy1/2=0.
  - claim_stall=0 while rst=1.
- Out-of-range addresses (NUM_REGS not a power of 2):
  - Reads return 0 and busy 0.
  - Writes and claims are ignored.

## Test plan
- Reset, then read all 16 addresses on both ports -> data 0x0000, busy 0 on every address.
- Write 0xBEEF to reg 5 with rd_addr1=5 in the same cycle:
  - rd_data1=0xBEEF in that cycle with BYPASS=1.
  - Next cycle rd_data1=0xBEEF with BYPASS=0.
- Write 0x1234 to reg 0 and claim reg 0 -> rd_data=0, rd_busy=0, claim_stall=0 on all following cycles (ZERO_REG=1).
- Claim reg 3 three times with PEND_W=2:
  - rd_busy=1 from the cycle after the first claim.
  - A fourth claim gives claim_stall=1 and the counter stays 3.
  - Three writebacks to reg 3 give rd_busy=0 during the third writeback cycle.
- Claim reg 7 and write back reg 7 in the same cycle with pend=1 -> pend stays 1 and rd_busy1=1 on the next cycle.
- Claim regs 2 and 4, then assert rst for one cycle with wr_en=1 to reg 2 -> all busy 0 and reg 2 reads 0 after reset.
